// File: rtl/ff_sync_debounce.sv
// Multi-channel CDC input conditioner: flip-flop synchroniser chain, sample-enabled
// stability filter and registered rise/fall pulses for each channel.
module ff_sync_debounce #(
  parameter int                   CHANNELS    = 4,
  parameter int                   STAGES      = 2,
  parameter int                   FILTER_LEN  = 4,
  parameter logic [CHANNELS-1:0]  RESET_VALUE = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_en,
  input  logic [CHANNELS-1:0] async_data,
  output logic [CHANNELS-1:0] sync_data,
  output logic [CHANNELS-1:0] filt_data,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                changed
);

  localparam int              CNT_W    = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  generate
    if (STAGES < 2) begin : g_bad_stages
      $error("ff_sync_debounce: STAGES must be >= 2");
    end
    if (FILTER_LEN < 1) begin : g_bad_filter
      $error("ff_sync_debounce: FILTER_LEN must be >= 1");
    end
  endgenerate

  // Synchroniser chain: every stage is kept so metastability settles over the full depth.
  (* ASYNC_REG = "TRUE", keep = "true", dont_touch = "true" *)
  logic [CHANNELS-1:0] sync_p [STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        sync_p[k] <= RESET_VALUE;
      end
    end else begin
      sync_p[0] <= async_data;
      for (int k = 1; k < STAGES; k++) begin
        sync_p[k] <= sync_p[k-1];
      end
    end
  end

  assign sync_data = sync_p[STAGES-1];

  // Stability filter: accept a change only after FILTER_LEN consecutive differing samples.
  logic [CNT_W-1:0]    cnt [CHANNELS];
  logic [CHANNELS-1:0] differ;
  logic [CHANNELS-1:0] update;

  always_comb begin
    differ = sync_data ^ filt_data;
    update = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      update[i] = sample_en & differ[i] & (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= '0;
      end
      filt_data <= RESET_VALUE;
      rise      <= '0;
      fall      <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (sample_en) begin
          if (!differ[i] || update[i]) begin
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end
      end
      filt_data <= (filt_data & ~update) | (sync_data & update);
      rise      <= update & sync_data;
      fall      <= update & ~sync_data;
    end
  end

  assign changed = |(rise | fall);

endmodule

// File: tb/tb_ff_sync_debounce.sv
// Bench for ff_sync_debounce: three instances with different parameters share the
// stimulus; per-cycle expectations go through a queue and are checked after each edge.
module tb_ff_sync_debounce;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_en;
  logic [3:0] async_data;

  logic [3:0] sync_a, filt_a, rise_a, fall_a;
  logic       changed_a;
  logic [3:0] sync_b, filt_b, rise_b, fall_b;
  logic       changed_b;
  logic [3:0] sync_c, filt_c, rise_c, fall_c;
  logic       changed_c;

  always #5 clk = ~clk;

  ff_sync_debounce #(.CHANNELS(4), .STAGES(2), .FILTER_LEN(3), .RESET_VALUE(4'b1010)) u_a (
    .clk(clk), .reset(reset), .sample_en(sample_en), .async_data(async_data),
    .sync_data(sync_a), .filt_data(filt_a), .rise(rise_a), .fall(fall_a), .changed(changed_a));

  ff_sync_debounce #(.CHANNELS(4), .STAGES(2), .FILTER_LEN(3), .RESET_VALUE(4'b0000)) u_b (
    .clk(clk), .reset(reset), .sample_en(sample_en), .async_data(async_data),
    .sync_data(sync_b), .filt_data(filt_b), .rise(rise_b), .fall(fall_b), .changed(changed_b));

  ff_sync_debounce #(.CHANNELS(4), .STAGES(2), .FILTER_LEN(4), .RESET_VALUE(4'b0000)) u_c (
    .clk(clk), .reset(reset), .sample_en(sample_en), .async_data(async_data),
    .sync_data(sync_c), .filt_data(filt_c), .rise(rise_c), .fall(fall_c), .changed(changed_c));

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] din;
    logic [3:0] sync;
    logic [3:0] filt;
    logic [3:0] rise;
    logic [3:0] fall;
  } vec_t;

  typedef struct {
    int         inst;
    string      tag;
    logic [3:0] sync;
    logic [3:0] filt;
    logic [3:0] rise;
    logic [3:0] fall;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[32];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input string field, input logic [3:0] act,
                       input logic [3:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s %s: got %b expected %b", tag, field, act, want);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, then check after the edge.
  task automatic step(input logic r, input logic en, input logic [3:0] din, input int inst,
                      input string tag, input logic [3:0] es, input logic [3:0] ef,
                      input logic [3:0] er, input logic [3:0] efl);
    exp_t       e;
    logic [3:0] s, f, ri, fa;
    logic       ch;
    reset      = r;
    sample_en  = en;
    async_data = din;
    e.inst = inst; e.tag = tag; e.sync = es; e.filt = ef; e.rise = er; e.fall = efl;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    case (e.inst)
      0:       begin s = sync_a; f = filt_a; ri = rise_a; fa = fall_a; ch = changed_a; end
      1:       begin s = sync_b; f = filt_b; ri = rise_b; fa = fall_b; ch = changed_b; end
      default: begin s = sync_c; f = filt_c; ri = rise_c; fa = fall_c; ch = changed_c; end
    endcase
    check(e.tag, "sync_data", s, e.sync);
    check(e.tag, "filt_data", f, e.filt);
    check(e.tag, "rise", ri, e.rise);
    check(e.tag, "fall", fa, e.fall);
    check(e.tag, "changed", {3'b000, ch}, {3'b000, |(e.rise | e.fall)});
  endtask

  function automatic vec_t mk(input logic [3:0] din, input logic [3:0] s, input logic [3:0] f,
                              input logic [3:0] r, input logic [3:0] fl);
    vec_t v;
    v.rst = 1'b0; v.en = 1'b1; v.din = din; v.sync = s; v.filt = f; v.rise = r; v.fall = fl;
    return v;
  endfunction

  initial begin
    reset      = 1'b1;
    sample_en  = 1'b1;
    async_data = 4'b0101;

    // Reset state on the instance with a non-zero reset value, input held opposite.
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 4'b0101, 0, "reset_a", 4'b1010, 4'b1010, 4'b0000, 4'b0000);
    end

    // Instance B (STAGES=2, FILTER_LEN=3): latency, glitch rejection, simultaneous edges.
    tbl[0]  = mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tbl[1]  = mk(4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    tbl[2]  = mk(4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    tbl[3]  = mk(4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    tbl[4]  = mk(4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000);
    tbl[5]  = mk(4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    tbl[6]  = mk(4'b0011, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    tbl[7]  = mk(4'b0011, 4'b0011, 4'b0001, 4'b0000, 4'b0000);
    tbl[8]  = mk(4'b0001, 4'b0011, 4'b0001, 4'b0000, 4'b0000);
    tbl[9]  = mk(4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    tbl[10] = mk(4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    tbl[11] = mk(4'b0011, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    tbl[12] = mk(4'b0011, 4'b0011, 4'b0001, 4'b0000, 4'b0000);
    tbl[13] = mk(4'b0011, 4'b0011, 4'b0001, 4'b0000, 4'b0000);
    tbl[14] = mk(4'b0001, 4'b0011, 4'b0001, 4'b0000, 4'b0000);
    tbl[15] = mk(4'b0001, 4'b0001, 4'b0011, 4'b0010, 4'b0000);
    tbl[16] = mk(4'b0001, 4'b0001, 4'b0011, 4'b0000, 4'b0000);
    tbl[17] = mk(4'b0001, 4'b0001, 4'b0011, 4'b0000, 4'b0000);
    tbl[18] = mk(4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010);
    tbl[19] = mk(4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    tbl[20] = mk(4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    tbl[21] = mk(4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    tbl[22] = mk(4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    tbl[23] = mk(4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    tbl[24] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
    tbl[25] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tbl[26] = mk(4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tbl[27] = mk(4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    tbl[28] = mk(4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    tbl[29] = mk(4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    tbl[30] = mk(4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0000);
    tbl[31] = mk(4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0000);

    for (int i = 0; i < 32; i++) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].din, 1, $sformatf("vec%0d", i),
           tbl[i].sync, tbl[i].filt, tbl[i].rise, tbl[i].fall);
    end

    // Instance C (FILTER_LEN=4): sample strobe once every 8 clocks.
    step(1'b1, 1'b1, 4'b0000, 2, "gate_rst", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    for (int k = 0; k < 36; k++) begin
      step(1'b0, (k % 8) == 7, 4'b0001, 2, $sformatf("gate%0d", k),
           (k >= 1) ? 4'b0001 : 4'b0000,
           (k >= 31) ? 4'b0001 : 4'b0000,
           (k == 31) ? 4'b0001 : 4'b0000,
           4'b0000);
    end

    // Instance C: reset lands one sample before acceptance; count restarts from scratch.
    step(1'b1, 1'b1, 4'b0000, 2, "mid_rst0", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    for (int k = 0; k < 14; k++) begin
      step(k == 5, 1'b1, 4'b0001, 2, $sformatf("mid%0d", k),
           ((k >= 1 && k <= 4) || k >= 7) ? 4'b0001 : 4'b0000,
           (k >= 11) ? 4'b0001 : 4'b0000,
           (k == 11) ? 4'b0001 : 4'b0000,
           4'b0000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
